mp_reg_file: RTL and testbench
==============================

# mp_reg_file

Parametrised multi-port integer register file with same-cycle write-to-read bypass and a per-register pending (busy) scoreboard. It replaces the single-write, dual-read register file in the decode/writeback path so that multi-issue writeback and hazard detection can share one block. x0 is hard-wired to zero. All state is cleared by a synchronous active-low reset.

## Interface
- REG_DATA_WIDTH_POW, 6, log2 of register width (64 bits).
- REG_MEM_DEPTH_POW, 5, log2 of register count (32 registers).
- NUM_READ, 2, number of read ports (1–4).
- NUM_WRITE, 2, number of write ports (1–3).
- clk_in  input  1  sole clock; all state updates on its rising edge.
- rst_n_in  input  1  synchronous active-low reset.
- rs_in  input  NUM_READ x REG_MEM_DEPTH_POW  read register indices.
- rd_in  input  NUM_WRITE x REG_MEM_DEPTH_POW  write register indices.
- data_write  input  NUM_WRITE x REG_DATA_WIDTH  write data.
- write_en  input  NUM_WRITE  per-port write enable; also clears busy.
- alloc_en_in  input  1  mark alloc_rd_in as pending (instruction issued).
- alloc_rd_in  input  REG_MEM_DEPTH_POW  destination register being allocated.
- reg_data_out  output  NUM_READ x REG_DATA_WIDTH  read data, bypassed.
- busy_out  output  NUM_READ  source register still pending after this cycle's writes.

## Operation
- Storage: 2^REG_MEM_DEPTH_POW x 2^REG_DATA_WIDTH_POW flops plus one busy bit per register.
- Reset (rst_n_in low at edge): all registers := 0, all busy := 0. While rst_n_in is low, reg_data_out = 0 and busy_out = 0 combinationally.
- Write: at edge, for each port p with write_en[p] and rd_in[p] != 0, registers[rd_in[p]] := data_write[p]. Writes to x0 are discarded.
- Write collision (two ports, same nonzero rd): highest-index port wins, both for storage and bypass.
- Read port i: rs_in[i] == 0 -> 0. Else if any enabled write port targets rs_in[i] -> that port's data_write (highest index wins). Else registers[rs_in[i]].
- Busy set: alloc_en_in and alloc_rd_in != 0 -> busy[alloc_rd_in] := 1 at edge.
- Busy clear: each enabled write to a nonzero rd clears busy[rd] at edge.
- Set and clear on the same register in the same cycle: set wins (new producer supersedes the retiring one).
- busy_out[i] = busy[rs_in[i]] AND NOT (an enabled write targets rs_in[i] this cycle); x0 never busy. Alloc in the current cycle does not affect busy_out until the next cycle.
- No arithmetic; widths pass through unchanged, indices are unsigned.

## Timing
- Read latency: 0 cycles (combinational from rs_in, rd_in, write_en, data_write, state).
- Write visible: same cycle through bypass, next cycle from storage.
- Busy: set visible on busy_out one cycle after alloc_en_in; clear visible in the same cycle through the bypass term, and from state on the next cycle.
- Reset takes effect at the first rising edge with rst_n_in low. Writes and allocs presented in that cycle are ignored. Outputs are zero for the whole time rst_n_in is low.
- Reset in the middle of operation discards all pending busy bits. No pending write survives.

## Structure
- Shared package reg_file_pkg:
  - REG_DATA_WIDTH and REG_MEM_DEPTH localparams derived from the POW parameters.
  - reg_idx_t and reg_data_t typedefs.
  - REG_ZERO constant (index 0).
- One natural sub-module, rf_bypass_mux, instantiated per read port. It takes one read index, all write ports and the storage word, and returns the bypassed data and the busy term with highest-index priority.
- The top level holds storage, the busy vector, write decode and reset.

## Test plan
- Reset then read: hold rst_n_in low for 2 cycles after writing 0xDEAD to x5. Release, read rs_in[0]=5 -> reg_data_out[0]=0 and busy_out[0]=0.
- Bypass: write_en[0]=1, rd_in[0]=7, data 0x1234, with rs_in[1]=7 in the same cycle -> reg_data_out[1]=0x1234 that cycle. Next cycle, with write_en=0 -> still 0x1234.
- Collision: ports 0 and 1 both write x9 with 0xAA and 0xBB -> bypass shows 0xBB, and storage holds 0xBB next cycle.
- x0: write 0xFFFF to x0 and alloc x0 -> reads of x0 return 0, busy_out=0.
- Scoreboard: alloc x3 in cycle n -> busy_out=1 for rs=3 in cycle n+1. In cycle n+2, write x3 = 0x42 -> busy_out=0 and data 0x42 that cycle. Alloc and write x3 in the same cycle -> busy_out=1 the following cycle.
- Reset mid-operation: alloc x4, then assert reset -> busy_out for x4 is 0 after release and x4 reads 0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared widths, index/data types and the hard-wired zero register index
// for the multi-port register file.
package reg_file_pkg;

  localparam int DEF_DATA_WIDTH_POW = 6;
  localparam int DEF_MEM_DEPTH_POW  = 5;
  localparam int REG_DATA_WIDTH     = 1 << DEF_DATA_WIDTH_POW;
  localparam int REG_MEM_DEPTH      = 1 << DEF_MEM_DEPTH_POW;

  typedef logic [DEF_MEM_DEPTH_POW-1:0] reg_idx_t;
  typedef logic [REG_DATA_WIDTH-1:0]    reg_data_t;

  localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/mp_reg_file_bypass_mux.sv
// Per-read-port bypass: picks the highest-index enabled write that targets
// the read index, otherwise the stored word; x0 always reads as zero.
module rf_bypass_mux
  import reg_file_pkg::*;
#(
  parameter int DATA_W    = REG_DATA_WIDTH,
  parameter int AW        = DEF_MEM_DEPTH_POW,
  parameter int NUM_WRITE = 2
) (
  input  logic [AW-1:0]                     rs_in,
  input  logic [NUM_WRITE-1:0][AW-1:0]      rd_in,
  input  logic [NUM_WRITE-1:0][DATA_W-1:0]  data_write,
  input  logic [NUM_WRITE-1:0]              write_en,
  input  logic [DATA_W-1:0]                 stored_in,
  input  logic                              busy_in,
  output logic [DATA_W-1:0]                 data_out,
  output logic                              busy_out
);

  localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);

  always_comb begin
    data_out = stored_in;
    busy_out = busy_in;
    // Later ports overwrite earlier ones, giving highest-index priority.
    for (int p = 0; p < NUM_WRITE; p++) begin
      if (write_en[p] && (rd_in[p] == rs_in)) begin
        data_out = data_write[p];
        busy_out = 1'b0;
      end
    end
    if (rs_in == ZERO_IDX) begin
      data_out = '0;
      busy_out = 1'b0;
    end
  end

endmodule

// File: rtl/mp_reg_file.sv
// Multi-port integer register file with same-cycle write bypass and a
// per-register pending (busy) scoreboard; x0 is hard-wired to zero.
module mp_reg_file
  import reg_file_pkg::*;
#(
  parameter int REG_DATA_WIDTH_POW = DEF_DATA_WIDTH_POW,
  parameter int REG_MEM_DEPTH_POW  = DEF_MEM_DEPTH_POW,
  parameter int NUM_READ           = 2,
  parameter int NUM_WRITE          = 2
) (
  input  logic                                                 clk_in,
  input  logic                                                 rst_n_in,
  input  logic [NUM_READ-1:0][REG_MEM_DEPTH_POW-1:0]           rs_in,
  input  logic [NUM_WRITE-1:0][REG_MEM_DEPTH_POW-1:0]          rd_in,
  input  logic [NUM_WRITE-1:0][(1<<REG_DATA_WIDTH_POW)-1:0]    data_write,
  input  logic [NUM_WRITE-1:0]                                 write_en,
  input  logic                                                 alloc_en_in,
  input  logic [REG_MEM_DEPTH_POW-1:0]                         alloc_rd_in,
  output logic [NUM_READ-1:0][(1<<REG_DATA_WIDTH_POW)-1:0]     reg_data_out,
  output logic [NUM_READ-1:0]                                  busy_out
);

  localparam int DATA_W = 1 << REG_DATA_WIDTH_POW;
  localparam int AW     = REG_MEM_DEPTH_POW;
  localparam int DEPTH  = 1 << REG_MEM_DEPTH_POW;
  localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);

  logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [DEPTH-1:0]             busy_q, busy_d;

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int p = 0; p < NUM_WRITE; p++) begin
      if (write_en[p] && (rd_in[p] != ZERO_IDX)) begin
        regs_d[rd_in[p]] = data_write[p];
        busy_d[rd_in[p]] = 1'b0;
      end
    end
    // A new producer supersedes one retiring in the same cycle.
    if (alloc_en_in && (alloc_rd_in != ZERO_IDX)) begin
      busy_d[alloc_rd_in] = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_read
    logic [DATA_W-1:0] mux_data;
    logic              mux_busy;

    rf_bypass_mux #(
      .DATA_W    (DATA_W),
      .AW        (AW),
      .NUM_WRITE (NUM_WRITE)
    ) u_mux (
      .rs_in      (rs_in[i]),
      .rd_in      (rd_in),
      .data_write (data_write),
      .write_en   (write_en),
      .stored_in  (regs_q[rs_in[i]]),
      .busy_in    (busy_q[rs_in[i]]),
      .data_out   (mux_data),
      .busy_out   (mux_busy)
    );

    // Outputs are forced quiet for the whole time reset is held.
    assign reg_data_out[i] = rst_n_in ? mux_data : '0;
    assign busy_out[i]     = rst_n_in & mux_busy;
  end

endmodule

// File: tb/tb_mp_reg_file.sv
// Bench for mp_reg_file: directed vector table for the corner cases, then a
// randomised phase checked against a behavioural model through a queue.
module tb_mp_reg_file;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int EW = 2 * DW + 2;

  logic                  clk_in;
  logic                  rst_n_in;
  logic [1:0][AW-1:0]    rs_in;
  logic [1:0][AW-1:0]    rd_in;
  logic [1:0][DW-1:0]    data_write;
  logic [1:0]            write_en;
  logic                  alloc_en_in;
  logic [AW-1:0]         alloc_rd_in;
  logic [1:0][DW-1:0]    reg_data_out;
  logic [1:0]            busy_out;

  mp_reg_file #(
    .REG_DATA_WIDTH_POW (6),
    .REG_MEM_DEPTH_POW  (5),
    .NUM_READ           (2),
    .NUM_WRITE          (2)
  ) dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .rs_in        (rs_in),
    .rd_in        (rd_in),
    .data_write   (data_write),
    .write_en     (write_en),
    .alloc_en_in  (alloc_en_in),
    .alloc_rd_in  (alloc_rd_in),
    .reg_data_out (reg_data_out),
    .busy_out     (busy_out)
  );

  // ---------------- clock / reset ----------------
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic          rst_n;
    logic [AW-1:0] rs0, rs1;
    logic [1:0]    we;
    logic [AW-1:0] rd0, rd1;
    logic [DW-1:0] wd0, wd1;
    logic          alloc_en;
    logic [AW-1:0] alloc_rd;
    logic [DW-1:0] e_d0, e_d1;
    logic          e_b0, e_b1;
  } vec_t;

  vec_t          tbl[$];
  logic [EW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;

  // Behavioural model used by the random phase.
  logic [DW-1:0] m_regs[32];
  logic          m_busy[32];

  function automatic vec_t mk(input logic rst_n, input logic [AW-1:0] rs0, rs1,
                              input logic [1:0] we, input logic [AW-1:0] rd0, rd1,
                              input logic [DW-1:0] wd0, wd1, input logic alloc_en,
                              input logic [AW-1:0] alloc_rd, input logic [DW-1:0] e_d0, e_d1,
                              input logic e_b0, e_b1);
    vec_t v;
    v.rst_n = rst_n; v.rs0 = rs0; v.rs1 = rs1; v.we = we; v.rd0 = rd0; v.rd1 = rd1;
    v.wd0 = wd0; v.wd1 = wd1; v.alloc_en = alloc_en; v.alloc_rd = alloc_rd;
    v.e_d0 = e_d0; v.e_d1 = e_d1; v.e_b0 = e_b0; v.e_b1 = e_b1;
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check_one(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input int idx);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1 (cycle %0d)", idx);
      return;
    end
    e = exp_q.pop_front();
    check_one($sformatf("data0[%0d]", idx), reg_data_out[0], e[EW-1 -: DW]);
    check_one($sformatf("data1[%0d]", idx), reg_data_out[1], e[DW+1 : 2]);
    check_one($sformatf("busy0[%0d]", idx), DW'(busy_out[0]), DW'(e[1]));
    check_one($sformatf("busy1[%0d]", idx), DW'(busy_out[1]), DW'(e[0]));
  endtask

  // ---------------- driver ----------------
  task automatic apply_vec(input vec_t v, input int idx);
    @(negedge clk_in);
    rst_n_in      = v.rst_n;
    rs_in[0]      = v.rs0;
    rs_in[1]      = v.rs1;
    write_en      = v.we;
    rd_in[0]      = v.rd0;
    rd_in[1]      = v.rd1;
    data_write[0] = v.wd0;
    data_write[1] = v.wd1;
    alloc_en_in   = v.alloc_en;
    alloc_rd_in   = v.alloc_rd;
    exp_q.push_back({v.e_d0, v.e_d1, v.e_b0, v.e_b1});
    #4;
    check_outputs(idx);
  endtask

  function automatic logic [DW-1:0] model_data(input vec_t v, input logic [AW-1:0] rs);
    if (!v.rst_n || rs == 0) return '0;
    if (v.we[1] && v.rd1 == rs) return v.wd1;
    if (v.we[0] && v.rd0 == rs) return v.wd0;
    return m_regs[rs];
  endfunction

  function automatic logic model_busy(input vec_t v, input logic [AW-1:0] rs);
    if (!v.rst_n || rs == 0) return 1'b0;
    if ((v.we[1] && v.rd1 == rs) || (v.we[0] && v.rd0 == rs)) return 1'b0;
    return m_busy[rs];
  endfunction

  task automatic model_update(input vec_t v);
    if (!v.rst_n) begin
      for (int r = 0; r < 32; r++) begin
        m_regs[r] = '0;
        m_busy[r] = 1'b0;
      end
      return;
    end
    if (v.we[0] && v.rd0 != 0) begin m_regs[v.rd0] = v.wd0; m_busy[v.rd0] = 1'b0; end
    if (v.we[1] && v.rd1 != 0) begin m_regs[v.rd1] = v.wd1; m_busy[v.rd1] = 1'b0; end
    if (v.alloc_en && v.alloc_rd != 0) m_busy[v.alloc_rd] = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vec_t v;
    rst_n_in = 1'b0; rs_in = '0; rd_in = '0; data_write = '0;
    write_en = '0; alloc_en_in = 1'b0; alloc_rd_in = '0;

    //            rst rs0 rs1 we     rd0 rd1 wd0        wd1       al  ard e_d0       e_d1      b0 b1
    tbl.push_back(mk(0, 0,  0, 2'b00, 0,  0, 0,         0,        0,  0,  0,         0,        0, 0));
    tbl.push_back(mk(0, 5,  5, 2'b01, 5,  0, 64'h77,    0,        1,  5,  0,         0,        0, 0));
    tbl.push_back(mk(1, 5,  0, 2'b01, 5,  0, 64'hDEAD,  0,        0,  0,  64'hDEAD,  0,        0, 0));
    tbl.push_back(mk(0, 5,  5, 2'b00, 0,  0, 0,         0,        0,  0,  0,         0,        0, 0));
    tbl.push_back(mk(0, 5,  5, 2'b00, 0,  0, 0,         0,        0,  0,  0,         0,        0, 0));
    tbl.push_back(mk(1, 5,  5, 2'b00, 0,  0, 0,         0,        0,  0,  0,         0,        0, 0));
    tbl.push_back(mk(1, 5,  7, 2'b01, 7,  0, 64'h1234,  0,        0,  0,  0,         64'h1234, 0, 0));
    tbl.push_back(mk(1, 7,  7, 2'b00, 7,  0, 64'h9999,  0,        0,  0,  64'h1234,  64'h1234, 0, 0));
    tbl.push_back(mk(1, 9,  7, 2'b11, 9,  9, 64'hAA,    64'hBB,   0,  0,  64'hBB,    64'h1234, 0, 0));
    tbl.push_back(mk(1, 9,  9, 2'b00, 0,  0, 0,         0,        0,  0,  64'hBB,    64'hBB,   0, 0));
    tbl.push_back(mk(1, 0,  0, 2'b01, 0,  0, 64'hFFFF,  0,        1,  0,  0,         0,        0, 0));
    tbl.push_back(mk(1, 0,  0, 2'b00, 0,  0, 0,         0,        0,  0,  0,         0,        0, 0));
    tbl.push_back(mk(1, 3,  0, 2'b00, 0,  0, 0,         0,        1,  3,  0,         0,        0, 0));
    tbl.push_back(mk(1, 3,  0, 2'b00, 0,  0, 0,         0,        0,  0,  0,         0,        1, 0));
    tbl.push_back(mk(1, 3,  3, 2'b01, 3,  0, 64'h42,    0,        0,  0,  64'h42,    64'h42,   0, 0));
    tbl.push_back(mk(1, 3,  0, 2'b00, 0,  0, 0,         0,        0,  0,  64'h42,    0,        0, 0));
    tbl.push_back(mk(1, 3,  0, 2'b10, 0,  3, 0,         64'h55,   1,  3,  64'h55,    0,        0, 0));
    tbl.push_back(mk(1, 3,  4, 2'b00, 0,  0, 0,         0,        1,  4,  64'h55,    0,        1, 0));
    tbl.push_back(mk(1, 3,  4, 2'b00, 0,  0, 0,         0,        0,  0,  64'h55,    0,        1, 1));
    tbl.push_back(mk(0, 3,  4, 2'b00, 0,  0, 0,         0,        0,  0,  0,         0,        0, 0));
    tbl.push_back(mk(1, 4,  3, 2'b00, 0,  0, 0,         0,        0,  0,  0,         0,        0, 0));
    tbl.push_back(mk(1, 11, 10,2'b11, 10, 11,64'h111,   64'h222,  0,  0,  64'h222,   64'h111,  0, 0));
    tbl.push_back(mk(1, 10, 11,2'b00, 0,  0, 0,         0,        0,  0,  64'h111,   64'h222,  0, 0));

    foreach (tbl[i]) apply_vec(tbl[i], i);

    // Random phase starts from a reset so the model begins cleared.
    v = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply_vec(v, 1000);
    model_update(v);
    for (int c = 0; c < 400; c++) begin
      v.rst_n    = ($urandom_range(0, 39) != 0);
      v.rs0      = AW'($urandom_range(0, 7));
      v.rs1      = AW'($urandom_range(0, 7));
      v.we       = 2'($urandom_range(0, 3));
      v.rd0      = AW'($urandom_range(0, 7));
      v.rd1      = AW'($urandom_range(0, 7));
      v.wd0      = {$urandom, $urandom};
      v.wd1      = {$urandom, $urandom};
      v.alloc_en = ($urandom_range(0, 2) == 0);
      v.alloc_rd = AW'($urandom_range(0, 7));
      v.e_d0     = model_data(v, v.rs0);
      v.e_d1     = model_data(v, v.rs1);
      v.e_b0     = model_busy(v, v.rs0);
      v.e_b1     = model_busy(v, v.rs1);
      apply_vec(v, 2000 + c);
      model_update(v);
    end

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
